// File: rtl/intr_if.sv
// ---------------------------------------------------------------------------
// intr_if -- signal bundle between the interrupt controller and its
// surroundings (external request line, PC control unit, CCR).
//
//   irq_in        : asynchronous external request, rising-edge triggered
//   irq_mask      : 1 blocks the launch of new interrupts
//   instr_done    : instruction-boundary strobe from PC control
//   opcode, brx   : opcode / sub-op field of the current instruction
//   flags_in      : live CCR {Z,N,C,V}
//   intr          : interrupt launch to PC control
//   in_service    : high while a handler is executing
//   flags_saved   : CCR snapshot taken at launch
//   flags_restore : one-cycle strobe when RTI completes
//
// master = the environment driving requests, slave = the controller.
// ---------------------------------------------------------------------------
interface intr_if;
   logic       irq_in;
   logic       irq_mask;
   logic       instr_done;
   logic [3:0] opcode;
   logic [1:0] brx;
   logic [3:0] flags_in;
   logic       intr;
   logic       in_service;
   logic [3:0] flags_saved;
   logic       flags_restore;

   modport master (
      output irq_in, irq_mask, instr_done, opcode, brx, flags_in,
      input  intr, in_service, flags_saved, flags_restore
   );

   modport slave (
      input  irq_in, irq_mask, instr_done, opcode, brx, flags_in,
      output intr, in_service, flags_saved, flags_restore
   );
endinterface

// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl -- single-source, non-nesting interrupt controller.
//
// An asynchronous rising edge on irq_in is synchronised, turned into a
// one-cycle pulse and latched into a single pending bit. The controller
// launches the interrupt at the next unmasked instruction boundary,
// snapshots the CCR, and stays in service until an RTI retires, at which
// point the CCR restore is strobed.
//
// Ports:
//   clk   : clock, all state updates on its rising edge
//   reset : synchronous, active-low reset
//   bus   : intr_if.slave (request, instruction and flag signals)
// ---------------------------------------------------------------------------
module intr_ctrl (
   input  logic  clk,
   input  logic  reset,
   intr_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND    = 2'd1,
      SERVICE = 2'd2
   } state_e;

   localparam logic [3:0] OP_BRX  = 4'd11;
   localparam logic [1:0] BRX_RTI = 2'd3;

   state_e     state_q, state_d;
   logic       s1_q, s1_d;
   logic       s2_q, s2_d;
   logic       s3_q, s3_d;
   logic       pending_q, pending_d;
   logic [3:0] flags_saved_q, flags_saved_d;

   logic       edge_det;
   logic       launch;
   logic       rti;

   // s1/s2 form the synchroniser; s3 only remembers the previous s2 so a
   // rising edge shows up as a single-cycle pulse.
   assign edge_det = s2_q & ~s3_q;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      s1_d          = bus.irq_in;
      s2_d          = s1_q;
      s3_d          = s2_q;
      state_d       = state_q;
      pending_d     = pending_q | edge_det;   // further edges are absorbed
      flags_saved_d = flags_saved_q;
      launch        = 1'b0;
      rti           = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (edge_det) state_d = PEND;
         end
         PEND: begin
            if (bus.instr_done && !bus.irq_mask) begin
               launch        = 1'b1;
               state_d       = SERVICE;
               flags_saved_d = bus.flags_in;
               // An edge arriving in the launch cycle belongs to this request.
               pending_d     = 1'b0;
            end
         end
         SERVICE: begin
            // Only RTI leaves service; RET and everything else are ignored.
            if (bus.instr_done && bus.opcode == OP_BRX && bus.brx == BRX_RTI) begin
               rti     = 1'b1;
               state_d = (pending_q || edge_det) ? PEND : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The strobes are combinational; gating with reset keeps them quiet while
   // reset is held, so a request abandoned by reset never restores the CCR.
   assign bus.intr          = launch & reset;
   assign bus.flags_restore = rti & reset;
   assign bus.in_service    = (state_q == SERVICE);
   assign bus.flags_saved   = flags_saved_q;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (!reset) begin
         // NOTE: the CCR snapshot is reset too, so flags_saved reads a known
         // 0 before the first launch.
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         s3_q          <= 1'b0;
         pending_q     <= 1'b0;
         state_q       <= IDLE;
         flags_saved_q <= 4'b0000;
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         s3_q          <= s3_d;
         pending_q     <= pending_d;
         state_q       <= state_d;
         flags_saved_q <= flags_saved_d;
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl -- self-checking bench for intr_ctrl.
//
// Each cycle is one vector: inputs plus the outputs expected in that cycle.
// Inputs are driven on the falling clock edge and outputs sampled 2 ns later,
// before the next rising edge. Expected values are queued when a vector is
// driven and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_intr_ctrl;

   typedef struct {
      logic       rst;
      logic       irq;
      logic       mask;
      logic       done;
      logic [3:0] op;
      logic [1:0] brx;
      logic [3:0] flags;
      logic       e_intr;
      logic       e_ins;
      logic       e_fr;
      logic [3:0] e_fs;
   } vec_t;

   typedef struct {
      logic       intr;
      logic       ins;
      logic       fr;
      logic [3:0] fs;
      string      tag;
   } exp_t;

   logic clk;
   logic reset;
   intr_if bus ();

   intr_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n_step = 0;
   exp_t sb[$];

   function automatic vec_t mk(logic rst, logic irq, logic mask, logic done,
                               logic [3:0] op, logic [1:0] brx, logic [3:0] flags,
                               logic e_intr, logic e_ins, logic e_fr, logic [3:0] e_fs);
      vec_t v;
      v.rst = rst;   v.irq = irq;   v.mask = mask;   v.done = done;
      v.op = op;     v.brx = brx;   v.flags = flags;
      v.e_intr = e_intr; v.e_ins = e_ins; v.e_fr = e_fr; v.e_fs = e_fs;
      return v;
   endfunction

   task automatic check(string name, logic [3:0] act, logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Drive one vector, queue its expectations, then sample and compare.
   task automatic apply(vec_t v, string tag);
      exp_t e;
      @(negedge clk);
      reset          = v.rst;
      bus.irq_in     = v.irq;
      bus.irq_mask   = v.mask;
      bus.instr_done = v.done;
      bus.opcode     = v.op;
      bus.brx        = v.brx;
      bus.flags_in   = v.flags;
      e.intr = v.e_intr;
      e.ins  = v.e_ins;
      e.fr   = v.e_fr;
      e.fs   = v.e_fs;
      e.tag  = $sformatf("%s#%0d", tag, n_step);
      sb.push_back(e);
      n_step++;
      #2;
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard: got empty queue expected one entry");
      end else begin
         e = sb.pop_front();
         check({e.tag, ".intr"},          {3'b0, bus.intr},          {3'b0, e.intr});
         check({e.tag, ".in_service"},    {3'b0, bus.in_service},    {3'b0, e.ins});
         check({e.tag, ".flags_restore"}, {3'b0, bus.flags_restore}, {3'b0, e.fr});
         check({e.tag, ".flags_saved"},   bus.flags_saved,           e.fs);
      end
   endtask

   vec_t tbl[11];

   initial begin
      // Basic launch, RET ignored, RTI restore, snapshot held afterwards.
      //          rst irq msk dn op  brx flags     intr ins fr fs
      tbl[0]  = mk(0, 0, 0, 0, 0,  0, 4'b0000,   0, 0, 0, 4'b0000);
      tbl[1]  = mk(1, 1, 0, 0, 0,  0, 4'b0000,   0, 0, 0, 4'b0000);
      tbl[2]  = mk(1, 1, 0, 0, 0,  0, 4'b0000,   0, 0, 0, 4'b0000);
      tbl[3]  = mk(1, 1, 0, 0, 0,  0, 4'b0000,   0, 0, 0, 4'b0000);
      tbl[4]  = mk(1, 1, 0, 1, 0,  0, 4'b1010,   1, 0, 0, 4'b0000);
      tbl[5]  = mk(1, 1, 0, 1, 11, 2, 4'b0000,   0, 1, 0, 4'b1010);
      tbl[6]  = mk(1, 1, 0, 0, 11, 3, 4'b0000,   0, 1, 0, 4'b1010);
      tbl[7]  = mk(1, 1, 0, 1, 11, 3, 4'b0000,   0, 1, 1, 4'b1010);
      tbl[8]  = mk(1, 0, 0, 0, 0,  0, 4'b0000,   0, 0, 0, 4'b1010);
      tbl[9]  = mk(1, 0, 0, 1, 11, 3, 4'b0000,   0, 0, 0, 4'b1010);
      tbl[10] = mk(1, 0, 0, 1, 0,  0, 4'b0000,   0, 0, 0, 4'b1010);

      reset          = 1'b0;
      bus.irq_in     = 1'b0;
      bus.irq_mask   = 1'b0;
      bus.instr_done = 1'b0;
      bus.opcode     = 4'd0;
      bus.brx        = 2'd0;
      bus.flags_in   = 4'd0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 11; i++) apply(tbl[i], "basic");

      // Mask holds PEND through 5 boundaries; unmask launches.
      for (int i = 0; i < 3; i++) apply(mk(1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b1010), "mask");
      for (int i = 0; i < 5; i++) apply(mk(1, 1, 1, 1, 0, 0, 4'b0101, 0, 0, 0, 4'b1010), "mask");
      apply(mk(1, 1, 0, 0, 0, 0, 4'b0101, 0, 0, 0, 4'b1010), "mask");
      apply(mk(1, 1, 0, 1, 0, 0, 4'b0101, 1, 0, 0, 4'b1010), "mask");

      // Two edges in service, other opcodes ignored, one launch after RTI.
      apply(mk(1, 0, 0, 0, 0,  0, 4'b0000, 0, 1, 0, 4'b0101), "nest");
      apply(mk(1, 0, 0, 1, 5,  3, 4'b0000, 0, 1, 0, 4'b0101), "nest");
      apply(mk(1, 1, 0, 1, 11, 2, 4'b0000, 0, 1, 0, 4'b0101), "nest");
      apply(mk(1, 0, 0, 0, 0,  0, 4'b0000, 0, 1, 0, 4'b0101), "nest");
      apply(mk(1, 1, 0, 0, 0,  0, 4'b0000, 0, 1, 0, 4'b0101), "nest");
      for (int i = 0; i < 4; i++) apply(mk(1, 0, 0, 1, 2, 3, 4'b0000, 0, 1, 0, 4'b0101), "nest");
      apply(mk(1, 0, 0, 1, 11, 3, 4'b0000, 0, 1, 1, 4'b0101), "nest");
      apply(mk(1, 0, 0, 1, 0,  0, 4'b1111, 1, 0, 0, 4'b0101), "nest");
      apply(mk(1, 0, 0, 1, 11, 3, 4'b0000, 0, 1, 1, 4'b1111), "nest");
      for (int i = 0; i < 2; i++) apply(mk(1, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b1111), "nest");

      // Edge detected in the RTI cycle goes straight back to PEND.
      apply(mk(1, 1, 0, 0, 0,  0, 4'b0000, 0, 0, 0, 4'b1111), "simul");
      apply(mk(1, 0, 0, 0, 0,  0, 4'b0000, 0, 0, 0, 4'b1111), "simul");
      apply(mk(1, 0, 0, 0, 0,  0, 4'b0000, 0, 0, 0, 4'b1111), "simul");
      apply(mk(1, 0, 0, 1, 0,  0, 4'b0011, 1, 0, 0, 4'b1111), "simul");
      apply(mk(1, 1, 0, 0, 0,  0, 4'b0000, 0, 1, 0, 4'b0011), "simul");
      apply(mk(1, 0, 0, 0, 0,  0, 4'b0000, 0, 1, 0, 4'b0011), "simul");
      apply(mk(1, 0, 0, 1, 11, 3, 4'b0000, 0, 1, 1, 4'b0011), "simul");
      apply(mk(1, 0, 0, 1, 0,  0, 4'b1100, 1, 0, 0, 4'b0011), "simul");
      apply(mk(1, 0, 0, 1, 11, 3, 4'b0000, 0, 1, 1, 4'b1100), "simul");
      apply(mk(1, 0, 0, 1, 0,  0, 4'b0000, 0, 0, 0, 4'b1100), "simul");

      // Edge detected in the launch cycle is absorbed by that launch.
      apply(mk(1, 1, 0, 0, 0,  0, 4'b0000, 0, 0, 0, 4'b1100), "absorb");
      apply(mk(1, 0, 0, 0, 0,  0, 4'b0000, 0, 0, 0, 4'b1100), "absorb");
      apply(mk(1, 1, 0, 0, 0,  0, 4'b0000, 0, 0, 0, 4'b1100), "absorb");
      apply(mk(1, 0, 0, 0, 0,  0, 4'b0000, 0, 0, 0, 4'b1100), "absorb");
      apply(mk(1, 0, 0, 1, 0,  0, 4'b0110, 1, 0, 0, 4'b1100), "absorb");
      apply(mk(1, 0, 0, 1, 11, 3, 4'b0000, 0, 1, 1, 4'b0110), "absorb");
      for (int i = 0; i < 2; i++) apply(mk(1, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0110), "absorb");

      // Reset mid-service, irq held high through release, reset with RTI.
      for (int i = 0; i < 3; i++) apply(mk(1, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0110), "rst");
      apply(mk(1, 1, 0, 1, 0,  0, 4'b1001, 1, 0, 0, 4'b0110), "rst");
      apply(mk(0, 1, 0, 0, 0,  0, 4'b0000, 0, 1, 0, 4'b1001), "rst");
      apply(mk(1, 1, 0, 1, 0,  0, 4'b0000, 0, 0, 0, 4'b0000), "rst");
      apply(mk(1, 1, 0, 1, 0,  0, 4'b0000, 0, 0, 0, 4'b0000), "rst");
      apply(mk(1, 1, 0, 0, 0,  0, 4'b0000, 0, 0, 0, 4'b0000), "rst");
      apply(mk(1, 1, 0, 1, 0,  0, 4'b0001, 1, 0, 0, 4'b0000), "rst");
      apply(mk(0, 0, 0, 1, 11, 3, 4'b0000, 0, 1, 0, 4'b0001), "rst");
      for (int i = 0; i < 2; i++) apply(mk(1, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000), "rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The module SHALL have these ports: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 The module SHALL have these ports: reset  in  1  synchronous, active-low reset; 0 sampled at a clk edge resets the block.
REQ-003 The module SHALL have these ports: irq_in  in  1  asynchronous external interrupt request, edge-triggered on its rising edge.
REQ-004 The module SHALL have these ports: irq_mask  in  1  1 blocks the launch of new interrupts; pending requests are retained.
REQ-005 The module SHALL have these ports: instr_done  in  1  instruction-boundary strobe from the PC control unit.
REQ-006 The module SHALL have these ports: opcode  in  4  opcode of the current instruction.
REQ-007 The module SHALL have these ports: brx  in  2  sub-op field of the current instruction.
REQ-008 The module SHALL have these ports: flags_in  in  4  live CCR as {Z,N,C,V}.
REQ-009 The module SHALL have these ports: intr  out  1  interrupt launch to the PC control unit.
REQ-010 The module SHALL have these ports: in_service  out  1  high while a handler is executing.
REQ-011 The module SHALL have these ports: flags_saved  out  4  CCR snapshot taken at launch.
REQ-012 The module SHALL have these ports: flags_restore  out  1  one-cycle strobe at RTI completion; CCR then loads flags_saved.

Function
REQ-013 irq_in SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3; a detected edge is s2=1 and s3=0, one cycle wide.
REQ-014 A detected edge SHALL set a single pending bit; further edges while the bit is set SHALL be absorbed (no counting).
REQ-015 The state machine SHALL have 3 states: IDLE, PEND, SERVICE; state is registered.
REQ-016 In IDLE, a detected edge SHALL move the FSM to PEND at the next edge.
REQ-017 In PEND, intr SHALL be combinational and equal instr_done AND NOT irq_mask; intr SHALL be 0 in every other state.
REQ-018 In a PEND cycle with intr=1: at the next edge flags_saved SHALL load flags_in, pending SHALL clear, and the FSM SHALL move to SERVICE.
REQ-019 In PEND with irq_mask=1, the FSM SHALL hold PEND indefinitely; clearing the mask lets the next instr_done launch.
REQ-020 in_service SHALL be 1 exactly when the state is SERVICE.
REQ-021 In SERVICE, an RTI is a cycle with instr_done=1, opcode=4'd11 and brx=2'd3.
REQ-022 On an RTI in SERVICE, flags_restore SHALL be 1 in that same cycle (combinational) and 0 in all other cycles.
REQ-023 After an RTI, the FSM SHALL go to PEND at the next edge if pending is set or an edge is detected that cycle; otherwise it SHALL go to IDLE.
REQ-024 An edge detected during SERVICE SHALL set pending; it SHALL NOT launch until after the RTI (no nesting).
REQ-025 RET (opcode 11, brx 2) and all other opcodes in SERVICE SHALL have no effect on the FSM.
REQ-026 An edge detected in the same cycle as a launch SHALL be absorbed by the request being launched.
REQ-027 Minimum latency SHALL be: irq_in high at edge k, then s2=1 after edge k+1, then PEND after edge k+2; intr can assert in the cycle following edge k+2.
REQ-028 flags_saved SHALL hold its value until the next launch; it SHALL NOT change on RTI.

Reset
REQ-029 With reset=0 at an edge: s1, s2 and s3 SHALL be 0, pending SHALL be 0, the FSM SHALL be IDLE, and flags_saved SHALL be 4'b0000.
REQ-030 During and immediately after reset, intr=0, in_service=0 and flags_restore=0.
REQ-031 Reset asserted mid-SERVICE or mid-PEND SHALL abandon the request with no restore strobe.
REQ-032 irq_in held high through reset release SHALL produce one edge: s3=0 after reset, so the edge is detected two edges later.

Verification
REQ-033 Basic launch: irq_in rises; instr_done=1 in the cycle after PEND is entered, with flags_in=4'b1010 -> intr=1 for exactly that cycle, in_service=1 next cycle, flags_saved=4'b1010.
REQ-034 RTI restore: in SERVICE, drive opcode=11, brx=3, instr_done=1 -> flags_restore=1 for one cycle, then IDLE with in_service=0; opcode=11, brx=2 -> no change.
REQ-035 Mask: irq_mask=1, edge, 5 instr_done pulses -> intr stays 0 and the FSM stays PEND; drop the mask -> intr=1 at the next instr_done.
REQ-036 Nesting blocked: two edges during SERVICE -> no intr until RTI; after RTI, PEND and exactly one further launch, then IDLE after the second RTI.
REQ-037 Reset mid-service: reset=0 one cycle in SERVICE -> all outputs 0 and flags_saved=0 next cycle; no flags_restore strobe.
REQ-038 Simultaneous events: edge detected in the same cycle as RTI -> flags_restore=1, next state PEND, then one launch.
